// File: rtl/dds_fcw_sequencer.sv
// Frequency-sweep sequencer driving the DDS frequency control word as a dwell-timed staircase.
// Optional continuous looping of a sweep is enabled by defining DDS_SEQ_REPEAT_EN.
module dds_fcw_sequencer #(
  parameter int                FCW_W    = 32,
  parameter int                CNT_W    = 16,
  parameter logic [FCW_W-1:0]  IDLE_FCW = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [FCW_W-1:0] cfg_start_fcw,
  input  logic [FCW_W-1:0] cfg_step,
  input  logic [CNT_W-1:0] cfg_steps,
  input  logic [CNT_W-1:0] cfg_dwell,
`ifdef DDS_SEQ_REPEAT_EN
  input  logic             cfg_repeat,
`endif
  input  logic             stop,
  output logic [FCW_W-1:0] fcw,
  output logic             fcw_update,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [FCW_W-1:0] start_q, step_q;
  logic [CNT_W-1:0] steps_q, dwell_q;
  logic [CNT_W-1:0] dwell_cnt, rem;
  logic [CNT_W-1:0] dwell_in;
  logic             rep_q;
  logic             xfer;
  logic             hold, advance, finish;

  // A zero dwell still presents each FCW for one cycle.
  assign dwell_in = (cfg_dwell == '0) ? CNT_W'(1) : cfg_dwell;
  assign xfer     = (state == IDLE) && cfg_valid;

  // RUN-state decision tree, stop has priority over everything else
  assign hold     = (state == RUN) && !stop && (dwell_cnt > CNT_W'(1));
  assign advance  = (state == RUN) && !stop && !hold && (rem != '0);
  assign finish   = (state == RUN) && !stop && !hold && (rem == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_valid)            state_nxt = RUN;
      RUN:  if (stop)                 state_nxt = IDLE;
            else if (finish && !rep_q) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcw        <= IDLE_FCW;
      fcw_update <= 1'b0;
      done       <= 1'b0;
      dwell_cnt  <= '0;
      rem        <= '0;
      start_q    <= '0;
      step_q     <= '0;
      steps_q    <= '0;
      dwell_q    <= '0;
    end else begin
      fcw_update <= 1'b0;
      done       <= 1'b0;
      if (xfer) begin
        start_q    <= cfg_start_fcw;
        step_q     <= cfg_step;
        steps_q    <= cfg_steps;
        dwell_q    <= dwell_in;
        fcw        <= cfg_start_fcw;
        dwell_cnt  <= dwell_in;
        rem        <= cfg_steps;
        fcw_update <= 1'b1;
      end else if (state == RUN) begin
        if (stop) begin
          fcw        <= IDLE_FCW;
          fcw_update <= 1'b1;
        end else if (hold) begin
          dwell_cnt <= dwell_cnt - CNT_W'(1);
        end else if (advance) begin
          fcw        <= fcw + step_q;
          rem        <= rem - CNT_W'(1);
          dwell_cnt  <= dwell_q;
          fcw_update <= 1'b1;
        end else begin
          done <= 1'b1;
          // Looping pass restarts from the latched start value.
          if (rep_q) begin
            fcw        <= start_q;
            rem        <= steps_q;
            dwell_cnt  <= dwell_q;
            fcw_update <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DDS_SEQ_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset)     rep_q <= 1'b0;
    else if (xfer) rep_q <= cfg_repeat;
  end
`else
  assign rep_q = 1'b0;
`endif

endmodule

// File: doc/dds_fcw_sequencer.md
# dds_fcw_sequencer

Frequency-sweep controller for the QPSK modulator's `dds` carrier generator. It accepts a sweep descriptor over a valid/ready handshake and drives the DDS `fcw` input with a piecewise-constant staircase: start frequency, then fixed increments, each held for a programmable dwell. It sits between the modem control/register logic and the `dds` block. It is the only writer of the DDS frequency control word.

## Interface
- `FCW_W`, 32: width of frequency control word and step.
- `CNT_W`, 16: width of step-count and dwell counters.
- `IDLE_FCW`, 32'h0: FCW driven after reset and after an abort.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: sweep descriptor valid.
- `cfg_ready` out 1: sequencer can accept a descriptor; high only in IDLE.
- `cfg_start_fcw` in FCW_W: first FCW of the sweep.
- `cfg_step` in FCW_W: per-step increment, two's complement (negative values sweep down).
- `cfg_steps` in CNT_W: number of increments after the start value; 0 means a single segment.
- `cfg_dwell` in CNT_W: cycles each FCW is held; 0 is treated as 1.
- `stop` in 1: abort request.
- `fcw` out FCW_W: to `dds.fcw`; registered.
- `fcw_update` out 1: one-cycle pulse in every cycle where `fcw` takes a new value.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep pass completes normally.

## Operation
- Two states:
  - IDLE: `cfg_ready`=1, `busy`=0.
  - RUN: `cfg_ready`=0, `busy`=1.
- IDLE:
  - The transfer is `cfg_valid && cfg_ready`.
  - On a transfer, latch the descriptor and move to RUN.
  - Set `fcw`<=`cfg_start_fcw`, `dwell_cnt`<=max(`cfg_dwell`,1), `rem`<=`cfg_steps`, and pulse `fcw_update`.
  - `stop` is ignored in IDLE. If `stop` and `cfg_valid` are both high in IDLE, the descriptor is accepted.
- RUN, evaluated in priority order:
  1. `stop`=1: go to IDLE, `fcw`<=`IDLE_FCW`, pulse `fcw_update`, no `done`.
  2. `dwell_cnt`>1: decrement `dwell_cnt`.
  3. `dwell_cnt`==1 and `rem`>0: `fcw`<=`fcw`+`step` (modulo 2^FCW_W, wrap silently), `rem`<=`rem`-1, reload the dwell counter, pulse `fcw_update`.
  4. `dwell_cnt`==1 and `rem`==0: pulse `done` and go to IDLE. `fcw` holds its last value, with no `fcw_update`.
- Descriptor inputs are sampled only at the transfer. Changes to them while in RUN have no effect.
- Reset values:
  - State is IDLE.
  - `fcw`=`IDLE_FCW`.
  - `fcw_update`, `busy`, `done` = 0.
  - `cfg_ready`=1 from the first cycle after reset deasserts.
  - Internal counters are 0.
- Reset mid-sweep: on the next edge the block is in the reset state and `fcw`=`IDLE_FCW`. No `done` pulse.

## Timing
- Let N be the handshake cycle, S = `cfg_steps`, D = max(`cfg_dwell`,1).
- Cycle N+1: `fcw`=start, `fcw_update`=1, `busy`=1.
- Segment k (k=0..S) is `fcw`=start+k·step, presented for cycles N+1+k·D through N+(k+1)·D.
- Cycle N+1+(S+1)·D: `done`=1, `busy`=0, `cfg_ready`=1.
- A new descriptor may be accepted in the `done` cycle. Its start FCW appears on the following cycle, giving back-to-back sweeps with one hold cycle of the last FCW.
- `stop` sampled at cycle M in RUN: at M+1, `fcw`=`IDLE_FCW`, `busy`=0, `cfg_ready`=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `DDS_SEQ_REPEAT_EN`.
- Defined:
  - Adds input `cfg_repeat` (1 bit), latched at the transfer.
  - If latched 1, case 4 instead reloads `fcw`<=start, `rem`<=S, and the dwell counter. It pulses both `done` and `fcw_update` and stays in RUN.
  - The sweep loops until `stop` or `reset`.
- Undefined: the `cfg_repeat` port does not exist, and every sweep is single-pass.

## Test plan
- Basic ramp: start=32'h01000000, step=32'h01000000, steps=3, dwell=4. `fcw` is 01/02/03/04000000, each held 4 cycles starting at N+1. Exactly 4 `fcw_update` pulses. `done` at N+17.
- Wrap and negative step:
  - start=32'hFFFFFFF0, step=32'h20, steps=1, dwell=1 gives `fcw` FFFFFFF0 then 00000010, with `done` at N+3.
  - step=32'hFF000000 (−2^24) from 32'h04000000 gives a descending sequence.
- Dwell 0 and steps 0: dwell=0, steps=0. A single segment held 1 cycle, `done` at N+2, `cfg_ready` high again in the same cycle.
- Abort: `stop` asserted at segment 2 of the basic ramp. Next cycle `fcw`=`IDLE_FCW`, `fcw_update`=1, no `done` pulse. `cfg_valid` asserted while busy is not accepted.
- Reset mid-sweep: assert `reset` for 1 cycle during RUN. `fcw`=`IDLE_FCW`, `busy`=0. A new descriptor is accepted normally afterwards.
- Repeat (with `DDS_SEQ_REPEAT_EN`): steps=1, dwell=2, repeat=1. Sequence A,A,B,B,A,A,… with `done` every 4 cycles. `stop` ends the loop.
